counter_imu: RTL and testbench

- Free-running synthetic sample generator that stands in for an IMU data source in the FPGA IMU signal pipeline.
- Emits a new unsigned sample on every clock: a ramp 0, 1, 2, … MAX_VALUE that wraps to 0.
- Drives downstream filter/processing stages with a deterministic, easily checked pattern.

---
 rtl/counter_imu_pkg.sv | 7 +
 rtl/counter_imu.sv | 21 ++
 tb/tb_counter_imu.sv | 93 +++++++++
 3 files changed

// File: rtl/counter_imu_pkg.sv
// counter_imu_pkg: default IMU sample width and a helper that gives the largest value a WIDTH-bit sample can hold
package counter_imu_pkg;
  localparam int unsigned IMU_SAMPLE_W = 16;
  function automatic logic [31:0] max_for_width(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/counter_imu.sv
// counter_imu: free-running ramp 0..MAX_VALUE wrapping to 0; ports: clk, rst_n (async active-low clear), sample_out (registered count)
module counter_imu
  import counter_imu_pkg::*;
#(
  parameter int unsigned WIDTH = IMU_SAMPLE_W,
  parameter logic [31:0] MAX_VALUE = 32'd1000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sample_out
);
  localparam logic [WIDTH-1:0] MAX_W = MAX_VALUE[WIDTH-1:0];
  if (WIDTH < 1 || WIDTH > 32 || MAX_VALUE > max_for_width(WIDTH)) begin : g_bad_params
    $error("counter_imu: illegal WIDTH/MAX_VALUE combination");
  end
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (cnt == MAX_W) ? '0 : cnt + 1'b1;
  assign sample_out = cnt;
endmodule

// File: tb/tb_counter_imu.sv
// tb_counter_imu: randomized reset/run stimulus with a queued arithmetic reference model and a decoupled monitor
module tb_counter_imu;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] s_ramp, s_zero, s_dflt;
  logic [3:0] s_full;
  typedef struct {int ramp; int full; int zero; int dflt;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int k = 0;
  always #5 clk = ~clk;
  counter_imu #(.WIDTH(16), .MAX_VALUE(32'd10)) u_ramp (.clk(clk), .rst_n(rst_n), .sample_out(s_ramp));
  counter_imu #(.WIDTH(4), .MAX_VALUE(32'd15)) u_full (.clk(clk), .rst_n(rst_n), .sample_out(s_full));
  counter_imu #(.WIDTH(16), .MAX_VALUE(32'd0)) u_zero (.clk(clk), .rst_n(rst_n), .sample_out(s_zero));
  counter_imu u_dflt (.clk(clk), .rst_n(rst_n), .sample_out(s_dflt));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if ($time != 0) begin
      if (!rst_n) k = 0;
      else k++;
      q.push_back('{k % 11, k % 16, 0, k % 1001});
    end
  end
  initial begin
    exp_t e;
    int run_edges;
    int last_zero;
    run_edges = 0;
    last_zero = -1;
    #2;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow at %0t: got empty queue, expected an entry", $time);
      end else begin
        e = q.pop_front();
        check("ramp", {16'b0, s_ramp}, e.ramp);
        check("full", {28'b0, s_full}, e.full);
        check("zero", {16'b0, s_zero}, e.zero);
        check("dflt", {16'b0, s_dflt}, e.dflt);
      end
      if (rst_n === 1'b1) begin
        run_edges++;
        if (s_dflt == 16'd0) begin
          if (last_zero >= 0) check("period", run_edges - last_zero, 1001);
          last_zero = run_edges;
        end
      end else begin
        run_edges = 0;
        last_zero = -1;
      end
    end
  end
  initial begin
    int n;
    rst_n = 1'b0;
    #30 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    n = 0;
    @(negedge clk);
    while (k % 11 != 6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_six", k % 11, 6);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b1;
    end
    repeat (3100) @(posedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
